// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x480@60 timing constants, coordinate/colour types
//               and a small span helper for the VGA timing controller and
//               the pixel generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int unsigned C_COORD_W = 10;

  typedef logic [C_COORD_W-1:0] coord_t;

  // 8-bit colour as driven on the connector: {red[2:0], green[2:0], blue[1:0]}
  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb_t;

  localparam int unsigned C_H_VISIBLE = 640;
  localparam int unsigned C_H_FP      = 16;
  localparam int unsigned C_H_SYNC    = 96;
  localparam int unsigned C_H_BP      = 48;
  localparam int unsigned C_V_VISIBLE = 480;
  localparam int unsigned C_V_FP      = 10;
  localparam int unsigned C_V_SYNC    = 2;
  localparam int unsigned C_V_BP      = 33;

  localparam int unsigned C_H_TOTAL      = C_H_VISIBLE + C_H_FP + C_H_SYNC + C_H_BP;
  localparam int unsigned C_V_TOTAL      = C_V_VISIBLE + C_V_FP + C_V_SYNC + C_V_BP;
  localparam int unsigned C_H_SYNC_START = C_H_VISIBLE + C_H_FP;
  localparam int unsigned C_H_SYNC_END   = C_H_SYNC_START + C_H_SYNC - 1;
  localparam int unsigned C_V_SYNC_START = C_V_VISIBLE + C_V_FP;
  localparam int unsigned C_V_SYNC_END   = C_V_SYNC_START + C_V_SYNC - 1;

  // True when pos lies in the inclusive range [first, last]
  function automatic logic in_span(coord_t pos, coord_t first, coord_t last);
    return (pos >= first) && (pos <= last);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl_if
// Description : Pixel-request / display bundle between the timing controller
//               (master) and the pixel generator + connector (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_ctrl_if;
  import vga_timing_pkg::*;

  logic [7:0] next_color;
  logic       req;
  coord_t     col;
  coord_t     row;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       frame_start;

  modport master (
    input  next_color,
    output req, col, row, hsync, vsync, red, green, blue, frame_start
  );

  modport slave (
    output next_color,
    input  req, col, row, hsync, vsync, red, green, blue, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One timing axis: counts 0..max on inc, wraps to 0, and flags
//               the wrapping increment so the next axis can advance.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   inc,
  input  coord_t max,
  output coord_t count,
  output logic   wrap
);

  coord_t count_q;
  coord_t count_d;

  // A value at or above max wraps, so nothing outside 0..max survives an inc
  assign wrap = inc && (count_q >= max);

  // Next count: hold, step, or wrap to zero
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = wrap ? '0 : count_q + coord_t'(1);
    end
  end

  // Count register with synchronous reset to the axis origin
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA raster timing at half the clk rate. Issues one pixel
//               request per visible pixel, registers the returned colour
//               together with hsync/vsync so all display outputs stay aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = C_H_VISIBLE,
  parameter int unsigned H_FP      = C_H_FP,
  parameter int unsigned H_SYNC    = C_H_SYNC,
  parameter int unsigned H_BP      = C_H_BP,
  parameter int unsigned V_VISIBLE = C_V_VISIBLE,
  parameter int unsigned V_FP      = C_V_FP,
  parameter int unsigned V_SYNC    = C_V_SYNC,
  parameter int unsigned V_BP      = C_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_ctrl_if.master  bus
);

  localparam coord_t C_H_VIS   = coord_t'(H_VISIBLE);
  localparam coord_t C_V_VIS   = coord_t'(V_VISIBLE);
  localparam coord_t C_H_MAX   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t C_V_MAX   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t C_HS_FRST = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t C_HS_LAST = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t C_VS_FRST = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t C_VS_LAST = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic   phase_q, phase_d;
  logic   tick;
  coord_t hcnt, vcnt;
  logic   h_wrap;
  // The frame is sequenced entirely by the horizontal wrap; the vertical
  // wrap flag has no consumer here.
  logic   v_wrap_unused;
  logic   visible;
  rgb_t   rgb_q, rgb_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  // Pixel strobe: every second clk, first one on the clk after reset release
  assign tick = phase_q;

  vga_axis_counter u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (tick),
    .max   (C_H_MAX),
    .count (hcnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (h_wrap),
    .max   (C_V_MAX),
    .count (vcnt),
    .wrap  (v_wrap_unused)
  );

  assign visible = (hcnt < C_H_VIS) && (vcnt < C_V_VIS);

  // Next display state: captured only on tick clks, held otherwise
  always_comb begin
    phase_d = ~phase_q;
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (tick) begin
      rgb_d   = visible ? rgb_t'(bus.next_color) : '0;
      hsync_d = ~in_span(hcnt, C_HS_FRST, C_HS_LAST);
      vsync_d = ~in_span(vcnt, C_VS_FRST, C_VS_LAST);
    end
  end

  // Phase and display registers; reset blanks the screen with syncs idle
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign bus.req         = tick && visible;
  assign bus.frame_start = tick && (hcnt == '0) && (vcnt == '0);
  assign bus.col         = hcnt;
  assign bus.row         = vcnt;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.red         = rgb_q.red;
  assign bus.green       = rgb_q.green;
  assign bus.blue        = rgb_q.blue;

endmodule
`default_nettype wire
